program_sequencer: RTL and testbench

- Instruction-fetch stage directly upstream of the register-control decoder.
- Holds a small writable program of 4-bit opcodes, steps through it on start, and drives one opcode per clock onto `memoria`, which feeds the decoder's opcode input.
- Provides start/busy/done/err status to the testbench or host.
- Prevents repeated execution of an opcode: during stall or idle it drives `IDLE_OP`, a code outside the decoder table.

---
 rtl/program_sequencer.sv | 139 +++++++++++++
 tb/tb_program_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
//
// Instruction-fetch stage that sits directly in front of the register-control
// decoder. A small writable program of 4-bit opcodes is stepped through after
// `start`. One opcode per clock is issued on `memoria`. Whenever no command is
// being issued (idle, stalled, halted, faulted), IDLE_OP is driven instead.
// IDLE_OP lies outside the decoder table, so the decoder never sees the same
// opcode twice.
//
// Ports:
//   clock      in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   prog_we    in   program write enable (honoured only outside RUN)
//   prog_addr  in   [3:0] program write address
//   prog_data  in   [3:0] program write opcode
//   start      in   begin execution at address 0 (ignored during RUN)
//   stall      in   freeze stepping for this cycle
//   memoria    out  [3:0] registered opcode to the decoder
//   pc         out  [3:0] current fetch address
//   busy       out  high while in RUN
//   done       out  high while in DONE
//   err        out  high while in ERROR
// ---------------------------------------------------------------------------
module program_sequencer #(
   parameter int         DEPTH   = 16,
   parameter logic [3:0] MAX_OP  = 4'd5,
   parameter logic [3:0] HALT_OP = 4'hF,
   parameter logic [3:0] IDLE_OP = 4'hF
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       prog_we,
   input  logic [3:0] prog_addr,
   input  logic [3:0] prog_data,
   input  logic       start,
   input  logic       stall,
   output logic [3:0] memoria,
   output logic [3:0] pc,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

   state_t     state_r;
   logic [3:0] pc_r;
   logic [3:0] memoria_r;
   logic       busy_r;
   logic       done_r;
   logic       err_r;
   logic [3:0] mem_r [DEPTH];
   logic [3:0] word_s;

   // Asynchronous read of the word at the current fetch address.
   assign word_s = mem_r[pc_r];

   // Sequencer FSM plus program storage. Status flags are registered
   // alongside the state so that they stay glitch-free and mutually exclusive.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r   <= ST_IDLE;
         pc_r      <= 4'd0;
         memoria_r <= IDLE_OP;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= HALT_OP;
         end
      end else begin
         case (state_r)
            ST_RUN: begin
               if (stall) begin
                  // Never re-present a stalled opcode; pc simply waits.
                  memoria_r <= IDLE_OP;
               end else if (word_s <= MAX_OP) begin
                  memoria_r <= word_s;
                  if (pc_r == LAST_ADDR) begin
                     // End of memory: finish without wrapping.
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     pc_r <= pc_r + 4'd1;
                  end
               end else if (word_s == HALT_OP) begin
                  memoria_r <= IDLE_OP;
                  state_r   <= ST_DONE;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
               end else begin
                  // Code between MAX_OP and HALT_OP: pc stays on the culprit.
                  memoria_r <= IDLE_OP;
                  state_r   <= ST_ERROR;
                  busy_r    <= 1'b0;
                  err_r     <= 1'b1;
               end
            end
            ST_IDLE, ST_DONE, ST_ERROR: begin
               memoria_r <= IDLE_OP;
               // A write in the same cycle as start lands before the first fetch.
               if (prog_we) begin
                  mem_r[prog_addr] <= prog_data;
               end
               if (start) begin
                  pc_r    <= 4'd0;
                  state_r <= ST_RUN;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  err_r   <= 1'b0;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               memoria_r <= IDLE_OP;
               busy_r    <= 1'b0;
               done_r    <= 1'b0;
               err_r     <= 1'b0;
            end
         endcase
      end
   end

   assign memoria = memoria_r;
   assign pc      = pc_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign err     = err_r;

endmodule

// File: tb/tb_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_sequencer
//
// Directed bench for program_sequencer. The driver pushes each opcode that a
// run is expected to issue, together with the pc that should accompany it,
// into a scoreboard queue. An independent monitor pops one entry every time
// memoria carries something other than the idle code and compares it. Status
// and stall behaviour are checked by the driver at fixed points.
// ---------------------------------------------------------------------------
module tb_program_sequencer;

   logic       clock;
   logic       resetn;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [3:0] prog_data;
   logic       start;
   logic       stall;
   logic [3:0] memoria;
   logic [3:0] pc;
   logic       busy;
   logic       done;
   logic       err;

   typedef struct {
      logic [3:0] op;
      logic [3:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   program_sequencer dut (
      .clock    (clock),
      .resetn   (resetn),
      .prog_we  (prog_we),
      .prog_addr(prog_addr),
      .prog_data(prog_data),
      .start    (start),
      .stall    (stall),
      .memoria  (memoria),
      .pc       (pc),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Expected issue of the opcode stored at addr; pc has moved on by then,
   // except at the last address where it holds.
   task automatic push(input logic [3:0] op, input logic [3:0] addr);
      exp_t e;
      e.op = op;
      e.pc = (addr == 4'd15) ? 4'd15 : addr + 4'd1;
      exp_q.push_back(e);
   endtask

   task automatic do_write(input logic [3:0] a, input logic [3:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      @(negedge clock);
      prog_we   = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clock);
         n++;
      end
      chk("run_ends", {7'd0, busy}, 8'd0);
   endtask

   task automatic chk_drained(input string name);
      chk(name, 8'(exp_q.size()), 8'd0);
      exp_q.delete();
   endtask

   // Monitor: every non-idle code on memoria is an issued opcode.
   always @(negedge clock) begin
      exp_t e;
      if (resetn && memoria !== 4'hF) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_issue: got op %0h pc %0h expected none", memoria, pc);
         end else begin
            e = exp_q.pop_front();
            chk("issue_op", {4'd0, memoria}, {4'd0, e.op});
            chk("issue_pc", {4'd0, pc}, {4'd0, e.pc});
         end
      end
   end

   initial begin
      resetn    = 1'b0;
      prog_we   = 1'b0;
      prog_addr = 4'd0;
      prog_data = 4'd0;
      start     = 1'b0;
      stall     = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_mem",  {4'd0, memoria}, 8'h0F);
      chk("rst_pc",   {4'd0, pc}, 8'd0);
      chk("rst_flag", {5'd0, busy, done, err}, 8'd0);
      resetn = 1'b1;
      @(negedge clock);

      // Empty program: halts on the first fetch.
      do_start();
      chk("t1_busy", {7'd0, busy}, 8'd1);
      chk("t1_mem0", {4'd0, memoria}, 8'h0F);
      @(negedge clock);
      chk("t1_flags", {5'd0, busy, done, err}, 8'b010);
      chk("t1_pc",    {4'd0, pc}, 8'd0);
      chk("t1_mem1",  {4'd0, memoria}, 8'h0F);
      @(negedge clock);
      chk_drained("t1_drained");

      // Program 1,2,4,5,halt.
      do_write(4'd0, 4'd1);
      do_write(4'd1, 4'd2);
      do_write(4'd2, 4'd4);
      do_write(4'd3, 4'd5);
      do_write(4'd4, 4'hF);
      push(4'd1, 4'd0); push(4'd2, 4'd1); push(4'd4, 4'd2); push(4'd5, 4'd3);
      do_start();
      wait_end(40);
      chk("t2_flags", {5'd0, busy, done, err}, 8'b010);
      chk("t2_pc",    {4'd0, pc}, 8'd4);
      chk("t2_mem",   {4'd0, memoria}, 8'h0F);
      @(negedge clock);
      chk_drained("t2_drained");

      // Same program with a two-cycle stall after opcode 2.
      push(4'd1, 4'd0); push(4'd2, 4'd1); push(4'd4, 4'd2); push(4'd5, 4'd3);
      do_start();
      chk("t3_restart", {5'd0, busy, done, err}, 8'b100);
      @(negedge clock);
      @(negedge clock);
      stall = 1'b1;
      for (int s = 0; s < 2; s++) begin
         @(negedge clock);
         chk("t3_stall_mem", {4'd0, memoria}, 8'h0F);
         chk("t3_stall_pc",  {4'd0, pc}, 8'd2);
      end
      stall = 1'b0;
      wait_end(40);
      chk("t3_flags", {5'd0, busy, done, err}, 8'b010);
      chk("t3_pc",    {4'd0, pc}, 8'd4);
      @(negedge clock);
      chk_drained("t3_drained");

      // Illegal opcode 7 at address 2.
      do_write(4'd2, 4'd7);
      push(4'd1, 4'd0); push(4'd2, 4'd1);
      do_start();
      wait_end(40);
      chk("t4_flags", {5'd0, busy, done, err}, 8'b001);
      chk("t4_pc",    {4'd0, pc}, 8'd2);
      chk("t4_mem",   {4'd0, memoria}, 8'h0F);
      @(negedge clock);
      chk_drained("t4_drained");
      // Repair: halt at 3, then rewrite address 2 in the same cycle as start.
      do_write(4'd3, 4'hF);
      push(4'd1, 4'd0); push(4'd2, 4'd1); push(4'd3, 4'd2);
      prog_we   = 1'b1;
      prog_addr = 4'd2;
      prog_data = 4'd3;
      do_start();
      prog_we   = 1'b0;
      chk("t4_restart", {5'd0, busy, done, err}, 8'b100);
      wait_end(40);
      chk("t4b_flags", {5'd0, busy, done, err}, 8'b010);
      chk("t4b_pc",    {4'd0, pc}, 8'd3);
      @(negedge clock);
      chk_drained("t4b_drained");

      // Full memory of opcode 3, no halt word.
      for (int i = 0; i < 16; i++) begin
         do_write(4'(i), 4'd3);
      end
      for (int i = 0; i < 16; i++) begin
         push(4'd3, 4'(i));
      end
      do_start();
      wait_end(40);
      chk("t5_flags", {5'd0, busy, done, err}, 8'b010);
      chk("t5_pc",    {4'd0, pc}, 8'd15);
      @(negedge clock);
      chk("t5_mem",   {4'd0, memoria}, 8'h0F);
      chk("t5_pc2",   {4'd0, pc}, 8'd15);
      chk_drained("t5_drained");

      // Write to address 5 during RUN must be dropped.
      do_write(4'd0, 4'd1); do_write(4'd1, 4'd2); do_write(4'd2, 4'd3);
      do_write(4'd3, 4'd4); do_write(4'd4, 4'd5); do_write(4'd5, 4'd1);
      do_write(4'd6, 4'd2); do_write(4'd7, 4'hF);
      push(4'd1, 4'd0); push(4'd2, 4'd1); push(4'd3, 4'd2); push(4'd4, 4'd3);
      push(4'd5, 4'd4); push(4'd1, 4'd5); push(4'd2, 4'd6);
      do_start();
      prog_we   = 1'b1;
      prog_addr = 4'd5;
      prog_data = 4'd0;
      @(negedge clock);
      prog_we   = 1'b0;
      wait_end(40);
      chk("t6_flags", {5'd0, busy, done, err}, 8'b010);
      chk("t6_pc",    {4'd0, pc}, 8'd7);
      @(negedge clock);
      chk_drained("t6_drained");

      // Reset in the middle of a run.
      push(4'd1, 4'd0); push(4'd2, 4'd1); push(4'd3, 4'd2);
      do_start();
      repeat (3) @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      chk("t7_mem",   {4'd0, memoria}, 8'h0F);
      chk("t7_flags", {5'd0, busy, done, err}, 8'd0);
      chk("t7_pc",    {4'd0, pc}, 8'd0);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      chk_drained("t7_drained");

      // Every word must read back as halt: word a halts a run whose
      // earlier words have been made legal.
      for (int a = 0; a < 16; a++) begin
         for (int p = 0; p < a; p++) begin
            push(4'd1, 4'(p));
         end
         do_start();
         wait_end(40);
         chk("rb_flags", {5'd0, busy, done, err}, 8'b010);
         chk("rb_pc",    {4'd0, pc}, 8'(a));
         @(negedge clock);
         chk_drained("rb_drained");
         do_write(4'(a), 4'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
